// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the seg7 scan driver.
package seg7_pkg;

    // All segments off on an active-low gfedcba bus.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Whole-display blink phase: ON scans normally, OFF forces anodes off.
    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_e;

    // Digit index width; a single-digit display still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hex nibble to active-low gfedcba segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h18;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex-to-segment decoder for the currently scanned nibble.
module seg7_hex_lut (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    // Pure table lookup; registration happens in the driver.
    always_comb begin
        seg = hex_to_seg(nib);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with tear-free load,
// leading-zero blanking, guard time and whole-display blinking.
module seg7_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  upd_ack,
    output logic                  frame
);
    import seg7_pkg::*;

    localparam int VAL_W  = 4 * N_DIGITS;
    localparam int IDX_W  = idx_width(N_DIGITS);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int BLK_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    // State
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]    pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                pend_valid_q, pend_valid_d;
    logic                ack_due_q, ack_due_d;
    blink_phase_e        blink_phase_q, blink_phase_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;

    // Registered outputs
    logic [6:0]          seg_q, seg_d;
    logic                dp_n_q, dp_n_d;
    logic [N_DIGITS-1:0] an_n_q, an_n_d;
    logic                upd_ack_q, upd_ack_d;
    logic                frame_q, frame_d;

    // Combinational helpers
    logic                slot_wrap_s;
    logic                boundary_s;
    logic [IDX_W+1:0]    nib_base_s;
    logic [3:0]          cur_nib_s;
    logic [6:0]          lut_seg_s;
    logic [N_DIGITS-1:0] lz_mask_s;
    logic                blank_cur_s;
    logic                anodes_off_s;

    // Slot counter and digit index; last slot of the last digit is the frame boundary.
    always_comb begin
        slot_d      = slot_q;
        idx_d       = idx_q;
        slot_wrap_s = (slot_q == SLOT_LAST);
        boundary_s  = slot_wrap_s && (idx_q == IDX_LAST);
        if (slot_wrap_s) begin
            slot_d = {SLOT_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // Load handshake: park data in pending, commit only at a frame boundary.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        ack_due_d    = 1'b0;
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        // A load on the boundary cycle itself bypasses the pending register.
        if (boundary_s && (load || pend_valid_q)) begin
            disp_val_d   = load ? value : pend_val_q;
            disp_dp_d    = load ? dp_in : pend_dp_q;
            pend_valid_d = 1'b0;
            ack_due_d    = 1'b1;
        end else begin
            ack_due_d = 1'b0;
        end
    end

    // Blink phase: toggles after BLINK_FRAMES boundaries, cleared while disabled.
    always_comb begin
        blink_phase_d = blink_phase_q;
        blink_cnt_d   = blink_cnt_q;
        if (!blink_en) begin
            blink_phase_d = BLINK_ON;
            blink_cnt_d   = {BLK_W{1'b0}};
        end else if (boundary_s) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_phase_d = (blink_phase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                blink_cnt_d   = {BLK_W{1'b0}};
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Leading-zero mask: bit k set when digits N-1..k are all zero; digit 0 always shown.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_mask_s = {N_DIGITS{1'b0}};
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (disp_val_q[4*k +: 4] == 4'h0);
            lz_mask_s[k] = zero_run;
        end
        lz_mask_s[0] = 1'b0;
    end

    // Select the nibble of the digit being scanned.
    always_comb begin
        nib_base_s = {idx_q, 2'b00};
        cur_nib_s  = disp_val_q[nib_base_s +: 4];
    end

    seg7_hex_lut u_hex_lut (
        .nib (cur_nib_s),
        .seg (lut_seg_s)
    );

    // Next values of the pin registers, derived from current scan state.
    always_comb begin
        blank_cur_s  = blank_lz && lz_mask_s[idx_q];
        // Blink gating uses the live enable so deassertion takes effect at once.
        anodes_off_s = (slot_q < GUARD_END) || (blink_en && (blink_phase_q == BLINK_OFF));
        seg_d        = blank_cur_s ? SEG_BLANK : lut_seg_s;
        dp_n_d       = ~disp_dp_q[idx_q];
        an_n_d       = {N_DIGITS{1'b1}};
        if (anodes_off_s) begin
            an_n_d = {N_DIGITS{1'b1}};
        end else begin
            for (int k = 0; k < N_DIGITS; k++) begin
                an_n_d[k] = (idx_q != IDX_W'(k));
            end
        end
        frame_d   = (slot_q == {SLOT_W{1'b0}}) && (idx_q == {IDX_W{1'b0}});
        upd_ack_d = ack_due_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q        <= {SLOT_W{1'b0}};
            idx_q         <= {IDX_W{1'b0}};
            disp_val_q    <= {VAL_W{1'b0}};
            disp_dp_q     <= {N_DIGITS{1'b0}};
            pend_val_q    <= {VAL_W{1'b0}};
            pend_dp_q     <= {N_DIGITS{1'b0}};
            pend_valid_q  <= 1'b0;
            ack_due_q     <= 1'b0;
            blink_phase_q <= BLINK_ON;
            blink_cnt_q   <= {BLK_W{1'b0}};
            seg_q         <= SEG_BLANK;
            dp_n_q        <= 1'b1;
            an_n_q        <= {N_DIGITS{1'b1}};
            upd_ack_q     <= 1'b0;
            frame_q       <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            ack_due_q     <= ack_due_d;
            blink_phase_q <= blink_phase_d;
            blink_cnt_q   <= blink_cnt_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            upd_ack_q     <= upd_ack_d;
            frame_q       <= frame_d;
        end
    end

    assign seg     = seg_q;
    assign dp_n    = dp_n_q;
    assign an_n    = an_n_q;
    assign upd_ack = upd_ack_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        blink_en;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        upd_ack;
    logic        frame;

    int vectors     = 0;
    int miscompares = 0;

    // Expected segment sets, packed {digit3, digit2, digit1, digit0}
    localparam logic [27:0] SEGS_0000  = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] SEGS_12AF  = {7'h79, 7'h24, 7'h08, 7'h0E};
    localparam logic [27:0] SEGS_2222  = {7'h24, 7'h24, 7'h24, 7'h24};
    localparam logic [27:0] SEGS_9B07  = {7'h18, 7'h03, 7'h40, 7'h78};
    localparam logic [27:0] SEGS_LZ50  = {7'h7F, 7'h7F, 7'h12, 7'h40};
    localparam logic [27:0] SEGS_LZ00  = {7'h7F, 7'h7F, 7'h7F, 7'h40};

    seg7_scan_driver #(
        .N_DIGITS     (4),
        .SCAN_DIV     (4),
        .GUARD        (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .seg      (seg),
        .dp_n     (dp_n),
        .an_n     (an_n),
        .upd_ack  (upd_ack),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One output sample at position j (0..15) of a frame.
    task automatic check_cycle(input int j, input logic [27:0] segs, input logic [3:0] dps,
                               input logic ack, input logic blank, input string tag);
        int         d;
        int         s;
        logic [3:0] one;
        logic [3:0] exp_an;
        d   = j / 4;
        s   = j % 4;
        one = 4'b0001;
        exp_an = (blank || s < 1) ? 4'hF : ~(one << d);
        chk($sformatf("%s/an j%0d", tag, j), {28'd0, an_n}, {28'd0, exp_an});
        chk($sformatf("%s/seg j%0d", tag, j), {25'd0, seg}, {25'd0, segs[d*7 +: 7]});
        chk($sformatf("%s/dp_n j%0d", tag, j), {31'd0, dp_n}, {31'd0, ~dps[d]});
        chk($sformatf("%s/ack j%0d", tag, j), {31'd0, upd_ack}, {31'd0, (j == 0) ? ack : 1'b0});
        chk($sformatf("%s/frame j%0d", tag, j), {31'd0, frame}, {31'd0, (j == 0)});
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (frame !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/sync"}, {31'd0, frame}, 32'd1);
    endtask

    task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps,
                               input logic ack, input logic blank, input string tag);
        wait_frame(tag);
        for (int j = 0; j < 16; j++) begin
            check_cycle(j, segs, dps, ack, blank, tag);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        blink_en = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst/seg", {25'd0, seg}, 32'h7F);
            chk("rst/an", {28'd0, an_n}, 32'hF);
            chk("rst/ack", {31'd0, upd_ack}, 32'd0);
            chk("rst/frame", {31'd0, frame}, 32'd0);
        end
        chk("rst/dp_n", {31'd0, dp_n}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/first_frame", {31'd0, frame}, 32'd1);
        check_frame(SEGS_0000, 4'b0000, 1'b0, 1'b0, "idle");

        // Mid-frame load of 12AF: old data held to the boundary
        for (int j = 0; j < 16; j++) begin
            check_cycle(j, SEGS_0000, 4'b0000, 1'b0, 1'b0, "hold0");
            if (j == 5) begin
                value = 16'h12AF;
                dp_in = 4'b0100;
                load  = 1'b1;
            end else if (j == 6) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        check_frame(SEGS_12AF, 4'b0100, 1'b1, 1'b0, "show12AF");
        check_frame(SEGS_12AF, 4'b0100, 1'b0, 1'b0, "keep12AF");

        // Two loads in one frame: single ack, last value wins
        for (int j = 0; j < 16; j++) begin
            check_cycle(j, SEGS_12AF, 4'b0100, 1'b0, 1'b0, "hold12AF");
            if (j == 3) begin
                value = 16'h1111;
                dp_in = 4'b0000;
                load  = 1'b1;
            end else if (j == 4) begin
                load = 1'b0;
            end else if (j == 8) begin
                value = 16'h2222;
                load  = 1'b1;
            end else if (j == 9) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        check_frame(SEGS_2222, 4'b0000, 1'b1, 1'b0, "show2222");
        check_frame(SEGS_2222, 4'b0000, 1'b0, 1'b0, "keep2222");

        // Load on the boundary cycle itself
        for (int j = 0; j < 16; j++) begin
            check_cycle(j, SEGS_2222, 4'b0000, 1'b0, 1'b0, "hold2222");
            if (j == 14) begin
                value = 16'h9B07;
                dp_in = 4'b0001;
                load  = 1'b1;
            end else if (j == 15) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        check_frame(SEGS_9B07, 4'b0001, 1'b1, 1'b0, "bnd9B07");
        check_frame(SEGS_9B07, 4'b0001, 1'b0, 1'b0, "keep9B07");

        // Leading-zero blanking
        blank_lz = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check_cycle(j, SEGS_9B07, 4'b0001, 1'b0, 1'b0, "lzhold");
            if (j == 3) begin
                value = 16'h0050;
                dp_in = 4'b0000;
                load  = 1'b1;
            end else if (j == 4) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        check_frame(SEGS_LZ50, 4'b0000, 1'b1, 1'b0, "lz0050");
        for (int j = 0; j < 16; j++) begin
            check_cycle(j, SEGS_LZ50, 4'b0000, 1'b0, 1'b0, "lzhold50");
            if (j == 3) begin
                value = 16'h0000;
                dp_in = 4'b1000;
                load  = 1'b1;
            end else if (j == 4) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        check_frame(SEGS_LZ00, 4'b1000, 1'b1, 1'b0, "lz0000");

        // Blinking: frames 3-4 and 7-8 counted from enable are dark
        blank_lz = 1'b0;
        blink_en = 1'b1;
        check_frame(SEGS_0000, 4'b1000, 1'b0, 1'b0, "blinkF1");
        check_frame(SEGS_0000, 4'b1000, 1'b0, 1'b0, "blinkF2");
        check_frame(SEGS_0000, 4'b1000, 1'b0, 1'b1, "blinkF3");
        check_frame(SEGS_0000, 4'b1000, 1'b0, 1'b1, "blinkF4");
        check_frame(SEGS_0000, 4'b1000, 1'b0, 1'b0, "blinkF5");
        check_frame(SEGS_0000, 4'b1000, 1'b0, 1'b0, "blinkF6");
        wait_frame("blinkF7");
        for (int j = 0; j < 16; j++) begin
            check_cycle(j, SEGS_0000, 4'b1000, 1'b0, (j <= 5), "blinkF7");
            if (j == 5) begin
                blink_en = 1'b0;
            end
            @(negedge clk);
        end
        check_frame(SEGS_0000, 4'b1000, 1'b0, 1'b0, "blinkoff");

        // Reset while a load is pending: discarded, no ack
        for (int j = 0; j < 6; j++) begin
            check_cycle(j, SEGS_0000, 4'b1000, 1'b0, 1'b0, "prerst");
            if (j == 2) begin
                value = 16'h1234;
                dp_in = 4'b1111;
                load  = 1'b1;
            end else if (j == 3) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2/seg", {25'd0, seg}, 32'h7F);
        chk("rst2/an", {28'd0, an_n}, 32'hF);
        chk("rst2/ack", {31'd0, upd_ack}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2/first_frame", {31'd0, frame}, 32'd1);
        check_frame(SEGS_0000, 4'b0000, 1'b0, 1'b0, "postrst1");
        check_frame(SEGS_0000, 4'b0000, 1'b0, 1'b0, "postrst2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed N-digit hexadecimal 7-segment display driver. It latches a packed N-nibble value with a tear-free load handshake and scans one digit per slot onto a shared active-low segment bus with one-hot active-low anodes. It also provides leading-zero blanking, per-digit decimal points, anti-ghosting guard time and whole-display blinking. It sits between ALU/result registers and the board display pins.

## Interface
- `N_DIGITS`, 4: digits driven; ≥1.
- `SCAN_DIV`, 50000: clock cycles per digit slot; ≥2.
- `GUARD`, 2: cycles at slot start with all anodes off; 0 ≤ GUARD < SCAN_DIV.
- `BLINK_FRAMES`, 64: full scan frames per blink half-period; ≥1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `load`  in  1  one-cycle request to display `value`/`dp_in`.
- `value`  in  4*N_DIGITS  packed hex nibbles; digit 0 = bits [3:0].
- `dp_in`  in  N_DIGITS  decimal point request per digit, 1 = lit.
- `blank_lz`  in  1  level; 1 = blank leading zeros.
- `blink_en`  in  1  level; 1 = blink whole display.
- `seg`  out  7  segments gfedcba, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  N_DIGITS  anode select, active-low one-hot or all-ones.
- `upd_ack`  out  1  one-cycle pulse when a load becomes visible.
- `frame`  out  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- Reset values (cycle after `rst_n` sampled low): slot counter 0, digit index 0, displayed value 0, displayed dp 0, pending_valid 0, blink phase 0, blink frame counter 0. Outputs: `seg`=7'h7F, `dp_n`=1, `an_n`=all ones, `upd_ack`=0, `frame`=0.
- Slot counter runs 0..SCAN_DIV-1. At terminal count it wraps and the digit index increments, wrapping N_DIGITS-1 → 0. That wrap is the frame boundary.
- Load: on `load`=1, `value`/`dp_in` are captured into a pending register and pending_valid is set. A later load before the boundary overwrites the pending data; only one ack is issued.
- At a frame boundary with pending_valid (or with `load`=1 in that same cycle, whose data takes precedence), the pending data moves to the displayed registers, pending_valid clears and `upd_ack` pulses. The display therefore never changes mid-frame.
- Digit content: the nibble is decoded with the hex table (0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→18, A→08, b→03, C→46, d→21, E→06, F→0E).
- Leading-zero blanking: with `blank_lz`=1, digit k is blanked (`seg`=7F) when digits N-1..k are all zero. Digit 0 is never blanked. `dp_n` still follows the displayed dp.
- Guard: while the slot counter < GUARD, `an_n` is all ones.
- Blink: with `blink_en`=1, the blink counter counts frame boundaries. After BLINK_FRAMES boundaries, the phase toggles and the counter clears. Phase 1 forces `an_n` all ones. `blink_en`=0 clears the phase and counter immediately.
- `blank_lz`/`blink_en` are levels sampled every cycle and need no handshake.

## Timing
- All outputs are registered: one cycle of latency from internal state (counter/index/displayed regs) to pins.
- `frame` pulses in the first output cycle of each digit-0 slot.
- Load-to-visible latency: from 1 cycle (load on a boundary cycle) to N_DIGITS*SCAN_DIV cycles.
- `upd_ack` is aligned with the first output cycle showing new data.
- Reset mid-frame or mid-pending discards pending data without an ack; scanning restarts at digit 0, slot count 0.
- Reset has priority over `load`.

## Structure
- Package `seg7_pkg`: `SEG_BLANK` = 7'h7F constant, `hex_to_seg` function holding the table above, digit index width via `$clog2`.
- Sub-module `seg7_hex_lut`: combinational, one instance on the muxed current nibble. The scan/handshake FSM stays in the top.

## Test plan
Use N_DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.
- Reset: hold `rst_n`=0 3 cycles → `seg`=7F, `an_n`=4'hF, `upd_ack`=0. After release, `frame` first pulses one cycle after the first digit-0 slot starts.
- Load mid-frame with `value`=16'h12AF, `dp_in`=4'b0100 → old data held until the boundary. `upd_ack` is one pulse. Then the sequence is `an_n`=1110/`seg`=0E, 1101/08, 1011/24 with `dp_n`=0, 0111/79. Each slot has `an_n`=F for 1 cycle first.
- Two loads (16'h1111 then 16'h2222) in the same frame → one `upd_ack`; only 2222 is displayed.
- Load coincident with the boundary cycle → new value shown in the immediately following digit-0 slot, with `upd_ack` the same cycle.
- `blank_lz`=1, `value`=16'h0050 → digits 3,2 `seg`=7F; digit 1 =12; digit 0 =40. With `value`=0, only digit 0 shows 40.
- `blink_en`=1 → `an_n` all F during frames 3-4, 7-8, …. Deasserting mid-blank restores scanning from the next cycle.
